uart_rx_deserializer: RTL and testbench

UART receive path: the counterpart of the TX serializer on the same serial line. It oversamples RX_IN at PRESCALE ticks per bit and detects the start bit. Each bit is decided by a 3-sample majority vote. The block shifts in WIDTH data bits LSB-first, optionally checks parity, checks the stop bit, and presents P_DATA with a one-cycle Data_Valid pulse. It sits between the pad-side RX line and the UART register or FIFO block.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sampler.sv | 40 ++++
 rtl/uart_rx_deserializer.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, default frame geometry, parity types.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_PRESCALE = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures three mid-bit samples of the RX line and presents their majority vote,
// with a strobe marking the first tick at which the vote is settled.
module uart_rx_sampler #(
    parameter int unsigned PRESCALE = 8,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_i,
    input  logic [CNT_W-1:0] edge_cnt_i,
    input  logic             enable_i,
    output logic             voted_o,
    output logic             sample_done_o
);

    localparam logic [CNT_W-1:0] TAP0 = CNT_W'(PRESCALE/2 - 1);
    localparam logic [CNT_W-1:0] TAP1 = CNT_W'(PRESCALE/2);
    localparam logic [CNT_W-1:0] TAP2 = CNT_W'(PRESCALE/2 + 1);
    localparam logic [CNT_W-1:0] DONE = CNT_W'(PRESCALE/2 + 2);

    logic [2:0] smp_q, smp_d;

    always_comb begin
        smp_d = smp_q;
        if (enable_i) begin
            if (edge_cnt_i == TAP0) smp_d[0] = rx_i;
            if (edge_cnt_i == TAP1) smp_d[1] = rx_i;
            if (edge_cnt_i == TAP2) smp_d[2] = rx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) smp_q <= '0;
        else        smp_q <= smp_d;
    end

    assign voted_o       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign sample_done_o = enable_i && (edge_cnt_i == DONE);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start detect, majority-voted bits, optional parity, stop check.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer (adds 2 cycles latency).
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA,
    output logic             Data_Valid,
    output logic             par_err,
    output logic             stp_err
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[0], RX_IN};
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_en_q, par_en_d;
    logic             par_typ_q, par_typ_d;
    logic             par_bad_q, par_bad_d;
    logic             arm_q, arm_d;
    logic             fin_ok_q, fin_ok_d;
    logic             fin_perr_q, fin_perr_d;
    logic             fin_serr_q, fin_serr_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             dv_q, dv_d;
    logic             perr_q, perr_d;
    logic             serr_q, serr_d;

    logic voted;
    logic sample_done;
    logic edge_wrap;

    uart_rx_sampler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_sampler (
        .clk           (clk),
        .rst_n         (rst),
        .rx_i          (rx_s),
        .edge_cnt_i    (edge_cnt_q),
        .enable_i      (state_q != IDLE),
        .voted_o       (voted),
        .sample_done_o (sample_done)
    );

    assign edge_wrap = (edge_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_bad_d  = par_bad_q;
        arm_d      = arm_q;
        fin_ok_d   = 1'b0;
        fin_perr_d = 1'b0;
        fin_serr_d = 1'b0;
        // Frame verdict is staged one cycle so outputs land a full frame after start detect.
        dv_d    = fin_ok_q;
        perr_d  = fin_perr_q;
        serr_d  = fin_serr_q;
        pdata_d = fin_ok_q ? shift_q : pdata_q;

        if (state_q != IDLE) begin
            edge_cnt_d = edge_wrap ? '0 : edge_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                if (!arm_q) begin
                    if (rx_s) arm_d = 1'b1;
                end else if (!rx_s) begin
                    // The detecting cycle is tick 0 of the start bit.
                    state_d    = START;
                    edge_cnt_d = CNT_W'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_bad_d  = 1'b0;
                end
            end
            START: begin
                if (sample_done && voted) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (edge_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_done) shift_d = {voted, shift_q[WIDTH-1:1]};
                if (edge_wrap) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_done) par_bad_d = voted ^ (^shift_q) ^ par_typ_q;
                if (edge_wrap)   state_d = STOP;
            end
            STOP: begin
                if (edge_wrap) begin
                    state_d    = IDLE;
                    fin_ok_d   = voted & ~par_bad_q;
                    fin_perr_d = par_bad_q;
                    fin_serr_d = ~voted;
                    // A low stop bit disarms detection until the line returns high.
                    if (!voted) arm_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            arm_q      <= 1'b1;
            fin_ok_q   <= 1'b0;
            fin_perr_q <= 1'b0;
            fin_serr_q <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bad_q  <= par_bad_d;
            arm_q      <= arm_d;
            fin_ok_q   <= fin_ok_d;
            fin_perr_q <= fin_perr_d;
            fin_serr_q <= fin_serr_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign Data_Valid = dv_q;
    assign par_err    = perr_q;
    assign stp_err    = serr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer (WIDTH=8, PRESCALE=8, default build).
module tb_uart_rx_deserializer;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       par_err;
    logic       stp_err;

    int n_checks;
    int n_errors;
    int cyc;

    int         dv_cnt;
    int         perr_cnt;
    int         serr_cnt;
    int         dv_cyc_log [8];
    logic [7:0] dv_dat_log [8];

    uart_rx_deserializer #(
        .WIDTH    (8),
        .PRESCALE (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        dv_cnt   = 0;
        perr_cnt = 0;
        serr_cnt = 0;
    end

    // Pulse monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (Data_Valid) begin
            dv_cyc_log[dv_cnt % 8] = cyc;
            dv_dat_log[dv_cnt % 8] = P_DATA;
            dv_cnt = dv_cnt + 1;
        end
        if (par_err) perr_cnt = perr_cnt + 1;
        if (stp_err) serr_cnt = serr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; drives one 8-tick-per-bit frame. rst_at > 0 pulls reset at that tick.
    task automatic send_frame(input logic [7:0] data, input logic use_par, input logic par_bit,
                              input logic stop_bit, input int rst_at, output int t0);
        logic [10:0] fr;
        int n;
        fr      = '0;
        fr[8:1] = data;
        if (use_par) begin
            fr[9]  = par_bit;
            fr[10] = stop_bit;
            n      = 11;
        end else begin
            fr[9] = stop_bit;
            n     = 10;
        end
        t0 = cyc + 1;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < 8; k++) begin
                if (rst_at > 0 && b * 8 + k == rst_at) begin
                    rst   = 1'b0;
                    RX_IN = 1'b1;
                    return;
                end
                RX_IN = fr[b];
                @(negedge clk);
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int t0, t1, dv0, pe0, se0;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = PAR_EVEN;

        repeat (3) @(negedge clk);
        check("rst_pdata", 32'(P_DATA), 32'h0);
        check("rst_dv",    32'(Data_Valid), 32'h0);
        check("rst_perr",  32'(par_err), 32'h0);
        check("rst_serr",  32'(stp_err), 32'h0);
        rst = 1'b1;
        idle(5);

        // Plain frame 0xA5
        dv0 = dv_cnt; pe0 = perr_cnt; se0 = serr_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, t0);
        idle(12);
        check("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("a5_latency",  32'(dv_cyc_log[(dv_cnt - 1) % 8] - t0), 32'd80);
        check("a5_pdata",    32'(P_DATA), 32'hA5);
        check("a5_errs",     32'((perr_cnt - pe0) + (serr_cnt - se0)), 32'd0);

        // Even parity, 0x3C has four ones so parity bit is 0
        PAR_EN = 1'b1; PAR_TYP = PAR_EVEN;
        dv0 = dv_cnt; pe0 = perr_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 0, t0);
        idle(12);
        check("3c_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("3c_latency",  32'(dv_cyc_log[(dv_cnt - 1) % 8] - t0), 32'd88);
        check("3c_pdata",    32'(P_DATA), 32'h3C);
        check("3c_perr",     32'(perr_cnt - pe0), 32'd0);

        dv0 = dv_cnt; pe0 = perr_cnt; se0 = serr_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0, t0);
        idle(12);
        check("3c_bad_perr", 32'(perr_cnt - pe0), 32'd1);
        check("3c_bad_dv",   32'(dv_cnt - dv0), 32'd0);
        check("3c_bad_serr", 32'(serr_cnt - se0), 32'd0);
        check("3c_bad_hold", 32'(P_DATA), 32'h3C);

        // 0x3D has five ones: even wants 1, so 0 is an error and P_DATA must hold 0x3C
        dv0 = dv_cnt; pe0 = perr_cnt;
        send_frame(8'h3D, 1'b1, 1'b0, 1'b1, 0, t0);
        idle(12);
        check("3d_even_perr", 32'(perr_cnt - pe0), 32'd1);
        check("3d_even_hold", 32'(P_DATA), 32'h3C);

        // Odd parity on 0x3D wants 0; PAR_TYP is changed mid-frame and must be ignored
        PAR_TYP = PAR_ODD;
        dv0 = dv_cnt; pe0 = perr_cnt;
        fork
            send_frame(8'h3D, 1'b1, 1'b0, 1'b1, 0, t0);
            begin
                repeat (30) @(negedge clk);
                PAR_TYP = PAR_EVEN;
                PAR_EN  = 1'b0;
            end
        join
        idle(12);
        check("3d_odd_dv",   32'(dv_cnt - dv0), 32'd1);
        check("3d_odd_perr", 32'(perr_cnt - pe0), 32'd0);
        check("3d_odd_data", 32'(P_DATA), 32'h3D);

        // Start glitch: two low ticks then high
        dv0 = dv_cnt; pe0 = perr_cnt; se0 = serr_cnt;
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        check("glitch_pulses", 32'((dv_cnt - dv0) + (perr_cnt - pe0) + (serr_cnt - se0)), 32'd0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 0, t0);
        idle(12);
        check("55_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("55_pdata",    32'(P_DATA), 32'h55);
        check("55_latency",  32'(dv_cyc_log[(dv_cnt - 1) % 8] - t0), 32'd80);

        // Stop bit low followed by a 200-tick line break
        dv0 = dv_cnt; se0 = serr_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, t0);
        RX_IN = 1'b0;
        repeat (200) @(negedge clk);
        idle(20);
        check("brk_serr",  32'(serr_cnt - se0), 32'd1);
        check("brk_dv",    32'(dv_cnt - dv0), 32'd0);
        check("brk_hold",  32'(P_DATA), 32'h55);
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 0, t0);
        idle(12);
        check("brk_rearm", 32'(P_DATA), 32'h42);

        // Back-to-back frames, no idle gap
        dv0 = dv_cnt;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, t0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 0, t1);
        idle(12);
        check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
        check("b2b_first",    32'(dv_dat_log[dv0 % 8]), 32'h01);
        check("b2b_second",   32'(dv_dat_log[(dv0 + 1) % 8]), 32'hFE);
        check("b2b_spacing",  32'(dv_cyc_log[(dv0 + 1) % 8] - dv_cyc_log[dv0 % 8]), 32'd80);
        check("b2b_start",    32'(t1 - t0), 32'd80);

        // Reset in the middle of a frame
        dv0 = dv_cnt; se0 = serr_cnt; pe0 = perr_cnt;
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 40, t0);
        #1;
        check("midrst_pdata", 32'(P_DATA), 32'h0);
        check("midrst_dv",    32'(Data_Valid), 32'h0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(10);
        check("midrst_nopulse", 32'((dv_cnt - dv0) + (serr_cnt - se0) + (perr_cnt - pe0)), 32'd0);
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 0, t0);
        idle(12);
        check("77_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("77_pdata",    32'(P_DATA), 32'h77);
        check("77_latency",  32'(dv_cyc_log[(dv_cnt - 1) % 8] - t0), 32'd80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
